// File: rtl/hazard_ctrl_pkg.sv
// Shared definitions for the pipeline hazard sequencer.
//  - state_t      : sequencer FSM states
//  - ZERO_ADDRESS : register x0, which never produces a hazard
//  - WAIT_W       : width of the memory-wait watchdog counter (covers MAX_WAIT up to 255)
package hazard_ctrl_pkg;

    typedef enum logic [1:0] {
        RUN      = 2'd0,
        MEM_WAIT = 2'd1,
        ERROR    = 2'd2
    } state_t;

    localparam logic [4:0] ZERO_ADDRESS = 5'b00000;
    localparam int         WAIT_W       = 8;

endpackage

// File: rtl/hazard_ctrl_sat_counter.sv
// Generic saturating up-counter.
// Ports:
//  clk  in  clock, rising edge
//  arst in  asynchronous reset, active-high (count -> 0)
//  clr  in  synchronous clear (count -> 0), wins over inc
//  inc  in  increment request; ignored once the count is all-ones
//  cnt  out current count
module hazard_ctrl_sat_counter #(
    parameter int W = 16
) (
    input  logic         clk,
    input  logic         arst,
    input  logic         clr,
    input  logic         inc,
    output logic [W-1:0] cnt
);

    logic [W-1:0] cnt_r;

    // Count register: clear has priority, increment stops at all-ones.
    always_ff @(posedge clk or posedge arst) begin
        if (arst) begin
            cnt_r <= {W{1'b0}};
        end else if (clr) begin
            cnt_r <= {W{1'b0}};
        end else if (inc && (cnt_r != {W{1'b1}})) begin
            cnt_r <= cnt_r + {{(W-1){1'b0}}, 1'b1};
        end else begin
            cnt_r <= cnt_r;
        end
    end

    assign cnt = cnt_r;

endmodule

// File: rtl/hazard_ctrl.sv
// Pipeline sequencer for the 5-stage core: resolves load-use stalls,
// taken-branch flushes and data-memory wait freezes, keeps a saturating
// stall-cycle counter and a memory-wait watchdog with a sticky error.
// Ports:
//  clk, arst                      clock / async active-high reset
//  id_rs1, id_rs2, ex_rd          register addresses for load-use detection
//  ex_mem_read, ex_branch_taken   EX-stage load / taken-branch indications
//  mem_req, dmem_ready            MEM-stage data-memory handshake
//  pc_we .. mem_wb_bubble         per-stage write enables and NOP controls
//  stall_cnt                      cycles with pc_we=0 since reset (saturating)
//  error                          sticky watchdog timeout
module hazard_ctrl
    import hazard_ctrl_pkg::*;
#(
    parameter int AddressSize = 5,
    parameter int CNT_W       = 16,
    parameter int MAX_WAIT    = 64
) (
    input  logic                   clk,
    input  logic                   arst,
    input  logic [AddressSize-1:0] id_rs1,
    input  logic [AddressSize-1:0] id_rs2,
    input  logic [AddressSize-1:0] ex_rd,
    input  logic                   ex_mem_read,
    input  logic                   ex_branch_taken,
    input  logic                   mem_req,
    input  logic                   dmem_ready,
    output logic                   pc_we,
    output logic                   if_id_we,
    output logic                   if_id_flush,
    output logic                   id_ex_we,
    output logic                   id_ex_bubble,
    output logic                   ex_mem_we,
    output logic                   mem_wb_bubble,
    output logic [CNT_W-1:0]       stall_cnt,
    output logic                   error
);

    localparam logic [AddressSize-1:0] ZERO_REG_S = AddressSize'(ZERO_ADDRESS);
    localparam logic [WAIT_W-1:0]      MAX_WAIT_S = WAIT_W'(MAX_WAIT);

    state_t            state_r;
    state_t            state_nxt_s;
    logic              error_r;
    logic [WAIT_W-1:0] wait_cnt_s;
    logic              load_use_s;
    logic              mem_stall_s;
    logic              freeze_s;
    logic              pc_we_s;
    logic              if_id_we_s;
    logic              if_id_flush_s;
    logic              id_ex_we_s;
    logic              id_ex_bubble_s;
    logic              ex_mem_we_s;
    logic              mem_wb_bubble_s;

    assign load_use_s  = ex_mem_read && (ex_rd != ZERO_REG_S) &&
                         ((ex_rd == id_rs1) || (ex_rd == id_rs2));
    assign mem_stall_s = mem_req && !dmem_ready;

    // Once in MEM_WAIT only dmem_ready releases the freeze; the access is already outstanding.
    assign freeze_s = ((state_r == RUN) && mem_stall_s) ||
                      ((state_r == MEM_WAIT) && !dmem_ready);

    // Next-state logic; the watchdog fires when the wait count hits MAX_WAIT still unanswered.
    always_comb begin
        state_nxt_s = state_r;
        case (state_r)
            RUN: begin
                if (mem_stall_s) begin
                    state_nxt_s = MEM_WAIT;
                end else begin
                    state_nxt_s = RUN;
                end
            end
            MEM_WAIT: begin
                if (dmem_ready) begin
                    state_nxt_s = RUN;
                end else if (wait_cnt_s == MAX_WAIT_S) begin
                    state_nxt_s = ERROR;
                end else begin
                    state_nxt_s = MEM_WAIT;
                end
            end
            ERROR: begin
                state_nxt_s = ERROR;
            end
            default: begin
                state_nxt_s = ERROR;
            end
        endcase
    end

    // Stage controls: freeze > branch > load-use, everything off in reset and ERROR.
    always_comb begin
        pc_we_s         = 1'b1;
        if_id_we_s      = 1'b1;
        if_id_flush_s   = 1'b0;
        id_ex_we_s      = 1'b1;
        id_ex_bubble_s  = 1'b0;
        ex_mem_we_s     = 1'b1;
        mem_wb_bubble_s = 1'b0;
        if (arst || (state_r == ERROR) ||
            ((state_r != RUN) && (state_r != MEM_WAIT))) begin
            pc_we_s     = 1'b0;
            if_id_we_s  = 1'b0;
            id_ex_we_s  = 1'b0;
            ex_mem_we_s = 1'b0;
        end else if (freeze_s) begin
            pc_we_s         = 1'b0;
            if_id_we_s      = 1'b0;
            id_ex_we_s      = 1'b0;
            ex_mem_we_s     = 1'b0;
            mem_wb_bubble_s = 1'b1;
        end else if (ex_branch_taken) begin
            // The younger instruction in ID is squashed, so any load-use on it is moot.
            if_id_flush_s  = 1'b1;
            id_ex_bubble_s = 1'b1;
        end else if (load_use_s) begin
            pc_we_s        = 1'b0;
            if_id_we_s     = 1'b0;
            id_ex_bubble_s = 1'b1;
        end else begin
            pc_we_s = 1'b1;
        end
    end

    // State and sticky error registers.
    always_ff @(posedge clk or posedge arst) begin
        if (arst) begin
            state_r <= RUN;
            error_r <= 1'b0;
        end else begin
            state_r <= state_nxt_s;
            error_r <= error_r || (state_nxt_s == ERROR);
        end
    end

    hazard_ctrl_sat_counter #(.W(WAIT_W)) u_wait_cnt (
        .clk  (clk),
        .arst (arst),
        .clr  (!freeze_s),
        .inc  (freeze_s),
        .cnt  (wait_cnt_s)
    );

    hazard_ctrl_sat_counter #(.W(CNT_W)) u_stall_cnt (
        .clk  (clk),
        .arst (arst),
        .clr  (1'b0),
        .inc  (!pc_we_s),
        .cnt  (stall_cnt)
    );

    assign pc_we         = pc_we_s;
    assign if_id_we      = if_id_we_s;
    assign if_id_flush   = if_id_flush_s;
    assign id_ex_we      = id_ex_we_s;
    assign id_ex_bubble  = id_ex_bubble_s;
    assign ex_mem_we     = ex_mem_we_s;
    assign mem_wb_bubble = mem_wb_bubble_s;
    assign error         = error_r;

endmodule

// File: tb/tb_hazard_ctrl.sv
// Directed bench for hazard_ctrl (CNT_W=4, MAX_WAIT=4).
// Control vector order: {pc_we, if_id_we, if_id_flush, id_ex_we, id_ex_bubble, ex_mem_we, mem_wb_bubble}
module tb_hazard_ctrl;

    logic       clk;
    logic       arst;
    logic [4:0] id_rs1;
    logic [4:0] id_rs2;
    logic [4:0] ex_rd;
    logic       ex_mem_read;
    logic       ex_branch_taken;
    logic       mem_req;
    logic       dmem_ready;
    logic       pc_we;
    logic       if_id_we;
    logic       if_id_flush;
    logic       id_ex_we;
    logic       id_ex_bubble;
    logic       ex_mem_we;
    logic       mem_wb_bubble;
    logic [3:0] stall_cnt;
    logic       error;

    int vec_cnt;
    int miss_cnt;

    localparam logic [6:0] CTL_NORMAL = 7'b1101010;
    localparam logic [6:0] CTL_LOADUSE = 7'b0001110;
    localparam logic [6:0] CTL_BRANCH = 7'b1111110;
    localparam logic [6:0] CTL_FREEZE = 7'b0000001;
    localparam logic [6:0] CTL_OFF = 7'b0000000;

    hazard_ctrl #(
        .AddressSize (5),
        .CNT_W       (4),
        .MAX_WAIT    (4)
    ) dut (
        .clk             (clk),
        .arst            (arst),
        .id_rs1          (id_rs1),
        .id_rs2          (id_rs2),
        .ex_rd           (ex_rd),
        .ex_mem_read     (ex_mem_read),
        .ex_branch_taken (ex_branch_taken),
        .mem_req         (mem_req),
        .dmem_ready      (dmem_ready),
        .pc_we           (pc_we),
        .if_id_we        (if_id_we),
        .if_id_flush     (if_id_flush),
        .id_ex_we        (id_ex_we),
        .id_ex_bubble    (id_ex_bubble),
        .ex_mem_we       (ex_mem_we),
        .mem_wb_bubble   (mem_wb_bubble),
        .stall_cnt       (stall_cnt),
        .error           (error)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vec_cnt = vec_cnt + 1;
        if (obs !== exp) begin
            miss_cnt = miss_cnt + 1;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [31:0] ctl_vec();
        return {25'd0, pc_we, if_id_we, if_id_flush, id_ex_we, id_ex_bubble, ex_mem_we, mem_wb_bubble};
    endfunction

    // Advance one clock; inputs change 1 ns after the rising edge.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic clear_in();
        id_rs1 = 5'd0;
        id_rs2 = 5'd0;
        ex_rd = 5'd0;
        ex_mem_read = 1'b0;
        ex_branch_taken = 1'b0;
        mem_req = 1'b0;
        dmem_ready = 1'b0;
    endtask

    initial begin
        logic [3:0] exp_cnt;
        vec_cnt = 0;
        miss_cnt = 0;
        arst = 1'b1;
        clear_in();
        step();
        step();
        check_val("reset_ctl", ctl_vec(), {25'd0, CTL_OFF});
        check_val("reset_stall_cnt", {28'd0, stall_cnt}, 32'd0);
        check_val("reset_error", {31'd0, error}, 32'd0);
        arst = 1'b0;
        #1;
        check_val("idle_ctl", ctl_vec(), {25'd0, CTL_NORMAL});

        // Load-use on rs2
        ex_mem_read = 1'b1; ex_rd = 5'd5; id_rs2 = 5'd5; id_rs1 = 5'd3;
        #1;
        check_val("loaduse_rs2_ctl", ctl_vec(), {25'd0, CTL_LOADUSE});
        step();
        clear_in();
        #1;
        check_val("loaduse_rs2_cnt", {28'd0, stall_cnt}, 32'd1);
        check_val("after_loaduse_ctl", ctl_vec(), {25'd0, CTL_NORMAL});

        // Load to x0 is never a hazard
        ex_mem_read = 1'b1; ex_rd = 5'd0; id_rs1 = 5'd0; id_rs2 = 5'd0;
        #1;
        check_val("x0_ctl", ctl_vec(), {25'd0, CTL_NORMAL});
        step();
        check_val("x0_cnt", {28'd0, stall_cnt}, 32'd1);

        // Branch overrides load-use
        ex_mem_read = 1'b1; ex_rd = 5'd7; id_rs1 = 5'd7; ex_branch_taken = 1'b1;
        #1;
        check_val("branch_ctl", ctl_vec(), {25'd0, CTL_BRANCH});
        step();
        check_val("branch_cnt", {28'd0, stall_cnt}, 32'd1);
        clear_in();

        // Load-use on rs1; non-load same register is not a hazard
        ex_rd = 5'd9; id_rs1 = 5'd9;
        #1;
        check_val("no_load_ctl", ctl_vec(), {25'd0, CTL_NORMAL});
        ex_mem_read = 1'b1;
        #1;
        check_val("loaduse_rs1_ctl", ctl_vec(), {25'd0, CTL_LOADUSE});
        step();
        clear_in();
        check_val("loaduse_rs1_cnt", {28'd0, stall_cnt}, 32'd2);

        // Memory wait 3 cycles with a branch pending, release on the 4th
        mem_req = 1'b1; dmem_ready = 1'b0; ex_branch_taken = 1'b1;
        for (int i = 0; i < 3; i++) begin
            #1;
            check_val($sformatf("wait_freeze_%0d", i), ctl_vec(), {25'd0, CTL_FREEZE});
            step();
        end
        dmem_ready = 1'b1;
        #1;
        check_val("wait_release_ctl", ctl_vec(), {25'd0, CTL_BRANCH});
        step();
        check_val("wait_stall_cnt", {28'd0, stall_cnt}, 32'd5);
        clear_in();
        #1;
        check_val("back_to_run_ctl", ctl_vec(), {25'd0, CTL_NORMAL});
        check_val("no_error_yet", {31'd0, error}, 32'd0);

        // Watchdog: 1 RUN cycle + 4 MEM_WAIT cycles frozen, then ERROR
        mem_req = 1'b1; dmem_ready = 1'b0;
        for (int i = 0; i < 5; i++) begin
            #1;
            check_val($sformatf("wd_freeze_%0d", i), ctl_vec(), {25'd0, CTL_FREEZE});
            check_val($sformatf("wd_error_low_%0d", i), {31'd0, error}, 32'd0);
            step();
        end
        check_val("wd_error", {31'd0, error}, 32'd1);
        check_val("wd_ctl", ctl_vec(), {25'd0, CTL_OFF});
        check_val("wd_cnt", {28'd0, stall_cnt}, 32'd10);
        dmem_ready = 1'b1;
        #1;
        check_val("err_sticky_ctl", ctl_vec(), {25'd0, CTL_OFF});

        // Saturation: ERROR keeps pc_we=0 for 20 cycles
        exp_cnt = 4'd10;
        for (int i = 0; i < 20; i++) begin
            step();
            exp_cnt = (exp_cnt == 4'hF) ? 4'hF : exp_cnt + 4'd1;
            check_val($sformatf("sat_%0d", i), {28'd0, stall_cnt}, {28'd0, exp_cnt});
        end
        check_val("sat_final", {28'd0, stall_cnt}, 32'hF);
        check_val("err_still", {31'd0, error}, 32'd1);

        // Async reset clears everything immediately
        arst = 1'b1;
        #1;
        check_val("arst_error", {31'd0, error}, 32'd0);
        check_val("arst_cnt", {28'd0, stall_cnt}, 32'd0);
        check_val("arst_ctl", ctl_vec(), {25'd0, CTL_OFF});
        step();
        arst = 1'b0;
        clear_in();
        #1;
        check_val("post_arst_ctl", ctl_vec(), {25'd0, CTL_NORMAL});
        step();
        check_val("post_arst_cnt", {28'd0, stall_cnt}, 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, miss_cnt);
        $finish;
    end

endmodule
